// File: rtl/pixel_blend_if.sv
// pixel_blend_if: pixel stream in, frame-buffer write port out.
// Ports: val/sync_x/sync_y/dvi_*/ccd_*/mode/alpha/wrfull -> slave; wrreq/wrdata <- slave.
interface pixel_blend_if;
    logic        val;
    logic [9:0]  sync_x;
    logic [9:0]  sync_y;
    logic [4:0]  dvi_r;
    logic [5:0]  dvi_g;
    logic [4:0]  dvi_b;
    logic [4:0]  ccd_r;
    logic [5:0]  ccd_g;
    logic [4:0]  ccd_b;
    logic [1:0]  mode;
    logic [3:0]  alpha;
    logic        wrfull;
    logic        wrreq;
    logic [35:0] wrdata;

    modport slave (
        input  val, sync_x, sync_y,
        input  dvi_r, dvi_g, dvi_b,
        input  ccd_r, ccd_g, ccd_b,
        input  mode, alpha, wrfull,
        output wrreq, wrdata
    );

    modport master (
        output val, sync_x, sync_y,
        output dvi_r, dvi_g, dvi_b,
        output ccd_r, ccd_g, ccd_b,
        output mode, alpha, wrfull,
        input  wrreq, wrdata
    );
endinterface

// File: rtl/pixel_blend_writer.sv
// pixel_blend_writer: composites DVI/CCD pixels, skid-buffers, writes frame FIFO.
// Ports: clk_25, rst_n (async low), bus (pixel_blend_if.slave),
//        frame_done, overflow, range_err, pix_count, drop_count.
// Macro BLEND_STATS_EN: implements the saturating drop_count (else tied to 0).
module pixel_blend_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int SKID_DEPTH = 4
) (
    input  logic         clk_25,
    input  logic         rst_n,
    pixel_blend_if.slave bus,
    output logic         frame_done,
    output logic         overflow,
    output logic         range_err,
    output logic [18:0]  pix_count,
    output logic [15:0]  drop_count
);
    localparam int AW = $clog2(SKID_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [9:0]    X_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0]    Y_LIM  = 10'(V_ACTIVE);
    localparam logic [9:0]    X_HALF = 10'(H_ACTIVE / 2);
    localparam logic [9:0]    X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]    Y_LAST = 10'(V_ACTIVE - 1);
    localparam logic [CW-1:0] DEPTH  = CW'(SKID_DEPTH);

    typedef enum logic [1:0] {
        M_DVI   = 2'b00,
        M_CCD   = 2'b01,
        M_BLEND = 2'b10,
        M_SPLIT = 2'b11
    } mode_e;

    // S1: capture, saturate alpha, form the weighted products
    logic       w_in_range;
    logic [3:0] w_a;
    logic [3:0] w_na;

    assign w_in_range = (bus.sync_x < X_LIM) && (bus.sync_y < Y_LIM);
    assign w_a        = (bus.alpha > 4'd8) ? 4'd8 : bus.alpha;
    assign w_na       = 4'd8 - w_a;

    logic        r_s1_vld;
    logic [9:0]  r_s1_x;
    logic [9:0]  r_s1_y;
    logic [15:0] r_s1_dvi;
    logic [15:0] r_s1_ccd;
    mode_e       r_s1_mode;
    logic [7:0]  r_pc_r, r_pd_r, r_pc_b, r_pd_b;
    logic [8:0]  r_pc_g, r_pd_g;
    logic        r_range_err;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_dvi    <= '0;
            r_s1_ccd    <= '0;
            r_s1_mode   <= M_DVI;
            r_pc_r      <= '0;
            r_pd_r      <= '0;
            r_pc_g      <= '0;
            r_pd_g      <= '0;
            r_pc_b      <= '0;
            r_pd_b      <= '0;
            r_range_err <= 1'b0;
        end else begin
            r_s1_vld <= bus.val && w_in_range;
            if (bus.val && !w_in_range)
                r_range_err <= 1'b1;
            if (bus.val) begin
                r_s1_x    <= bus.sync_x;
                r_s1_y    <= bus.sync_y;
                r_s1_dvi  <= {bus.dvi_r, bus.dvi_g, bus.dvi_b};
                r_s1_ccd  <= {bus.ccd_r, bus.ccd_g, bus.ccd_b};
                r_s1_mode <= mode_e'(bus.mode);
                r_pc_r    <= {3'b0, bus.ccd_r} * {4'b0, w_a};
                r_pd_r    <= {3'b0, bus.dvi_r} * {4'b0, w_na};
                r_pc_g    <= {3'b0, bus.ccd_g} * {5'b0, w_a};
                r_pd_g    <= {3'b0, bus.dvi_g} * {5'b0, w_na};
                r_pc_b    <= {3'b0, bus.ccd_b} * {4'b0, w_a};
                r_pd_b    <= {3'b0, bus.dvi_b} * {4'b0, w_na};
            end
        end
    end

    // S2: rounded divide by 8; weights sum to 8 so result fits the channel
    logic [4:0]  w_bl_r, w_bl_b;
    logic [5:0]  w_bl_g;
    logic [15:0] w_rgb;

    assign w_bl_r = 5'(({2'b0, r_pc_r} + {2'b0, r_pd_r} + 10'd4) >> 3);
    assign w_bl_g = 6'(({1'b0, r_pc_g} + {1'b0, r_pd_g} + 10'd4) >> 3);
    assign w_bl_b = 5'(({2'b0, r_pc_b} + {2'b0, r_pd_b} + 10'd4) >> 3);

    always_comb begin
        w_rgb = r_s1_dvi;
        unique case (r_s1_mode)
            M_DVI:   w_rgb = r_s1_dvi;
            M_CCD:   w_rgb = r_s1_ccd;
            M_BLEND: w_rgb = {w_bl_r, w_bl_g, w_bl_b};
            M_SPLIT: w_rgb = (r_s1_x < X_HALF) ? r_s1_dvi : r_s1_ccd;
        endcase
    end

    logic        r_s2_vld;
    logic        r_s2_last;
    logic [35:0] r_s2_word;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_word <= '0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= (r_s1_x == X_LAST) && (r_s1_y == Y_LAST);
            r_s2_word <= {r_s1_x, r_s1_y, w_rgb};
        end
    end

    // S3 + drain: skid FIFO; a pop frees a slot for the same-cycle push
    logic [35:0]   r_mem [SKID_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_pop, w_full, w_push, w_drop, w_last;

    assign w_pop  = (r_cnt != '0) && !bus.wrfull;
    assign w_full = (r_cnt == DEPTH);
    assign w_push = r_s2_vld && (!w_full || w_pop);
    assign w_drop = r_s2_vld && w_full && !w_pop;
    assign w_last = r_s2_vld && r_s2_last;

    always_ff @(posedge clk_25) begin
        if (w_push)
            r_mem[r_wptr] <= r_s2_word;
    end

    logic        r_wrreq;
    logic [35:0] r_wrdata;
    logic        r_frame_done;
    logic        r_overflow;
    logic [18:0] r_pix_count;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_cnt        <= '0;
            r_wrreq      <= 1'b0;
            r_wrdata     <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_pix_count  <= '0;
        end else begin
            r_wrreq      <= w_pop;
            r_frame_done <= w_last;
            r_cnt        <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr   <= r_rptr + 1'b1;
                r_wrdata <= r_mem[r_rptr];
            end
            if (w_drop)
                r_overflow <= 1'b1;
            if (w_last)
                r_pix_count <= '0;
            else if (w_push)
                r_pix_count <= r_pix_count + 19'd1;
        end
    end

`ifdef BLEND_STATS_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n)
            r_drop_count <= '0;
        else if (w_drop && (r_drop_count != 16'hFFFF))
            r_drop_count <= r_drop_count + 16'd1;
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 16'd0;
`endif

    assign bus.wrreq  = r_wrreq;
    assign bus.wrdata = r_wrdata;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign range_err  = r_range_err;
    assign pix_count  = r_pix_count;
endmodule
